// File: rtl/peripheral_wb_pkg.sv
// peripheral_wb_pkg
// Shared Wishbone definitions for the peripheral bus blocks.
//   - CTI_* : cycle-type-identifier encodings (classic, constant, incrementing, end)
//   - arb_state_t : arbiter FSM states
//   - rr_next() : round-robin pick over up to RR_MAX_NM requesters
package peripheral_wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  localparam int unsigned RR_MAX_NM = 8;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_t;

  // One-hot pick of the first requester found at last+1, last+2, ... (mod nm).
  // Returns all-zero when nobody requests.
  function automatic logic [RR_MAX_NM-1:0] rr_next(input logic [RR_MAX_NM-1:0] req,
                                                   input int unsigned         last,
                                                   input int unsigned         nm);
    logic [RR_MAX_NM-1:0] pick;
    int unsigned          idx;
    pick = '0;
    for (int unsigned k = 1; k <= RR_MAX_NM; k++) begin
      idx = (last + k) % nm;
      if (k <= nm && pick == '0 && req[idx[2:0]]) begin
        pick[idx[2:0]] = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/peripheral_arbiter_rr_wb.sv
// peripheral_arbiter_rr_wb
// Combinational round-robin picker.
//   req_i  : per-master request (wb_cyc)
//   last_i : index of the master granted most recently
//   gnt_o  : one-hot pick, zero when no request
//   idx_o  : binary index of the pick (0 when no request)
//   any_o  : at least one master is requesting
module peripheral_arbiter_rr_wb
  import peripheral_wb_pkg::*;
#(
  parameter int NM = 4,
  parameter int LW = $clog2(NM)
) (
  input  logic [NM-1:0] req_i,
  input  logic [LW-1:0] last_i,
  output logic [NM-1:0] gnt_o,
  output logic [LW-1:0] idx_o,
  output logic          any_o
);

  logic [RR_MAX_NM-1:0] req8;
  logic [RR_MAX_NM-1:0] pick8;

  always_comb begin
    req8           = '0;
    req8[NM-1:0]   = req_i;
    pick8          = rr_next(req8, 32'(last_i), NM);
    gnt_o          = pick8[NM-1:0];
    idx_o          = '0;
    for (int i = 0; i < RR_MAX_NM; i++) begin
      if (pick8[i]) idx_o = LW'(i);
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/peripheral_arbiter_wb.sv
// peripheral_arbiter_wb
// Round-robin Wishbone arbiter sharing one slave port between NM masters.
// Ownership is granted per bus cycle (wb_cyc) and held until the owner drops
// cyc; one idle cycle always separates two grants. Requests and responses are
// muxed combinationally, so the arbiter adds no response latency. An optional
// watchdog (TIMEOUT>0) answers a stalled transfer with a single err pulse.
// Ports:
//   wb_clk, wb_rst_n                 : clock, async active-low reset
//   m_adr_i..m_bte_i                 : packed per-master requests (master i at slice i)
//   m_dat_o, m_ack_o/m_err_o/m_rty_o : read data (broadcast), per-master responses
//   s_adr_o..s_bte_o                 : request to the shared slave
//   s_dat_i, s_ack_i/s_err_i/s_rty_i : slave response
//   grant_o                          : one-hot current owner, zero when idle
module peripheral_arbiter_wb
  import peripheral_wb_pkg::*;
#(
  parameter int NM      = 4,
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int TIMEOUT = 0
) (
  input  logic               wb_clk,
  input  logic               wb_rst_n,
  input  logic [NM*AW-1:0]   m_adr_i,
  input  logic [NM*DW-1:0]   m_dat_i,
  input  logic [NM*DW/8-1:0] m_sel_i,
  input  logic [NM-1:0]      m_we_i,
  input  logic [NM-1:0]      m_cyc_i,
  input  logic [NM-1:0]      m_stb_i,
  input  logic [NM*3-1:0]    m_cti_i,
  input  logic [NM*2-1:0]    m_bte_i,
  output logic [DW-1:0]      m_dat_o,
  output logic [NM-1:0]      m_ack_o,
  output logic [NM-1:0]      m_err_o,
  output logic [NM-1:0]      m_rty_o,
  output logic [AW-1:0]      s_adr_o,
  output logic [DW-1:0]      s_dat_o,
  output logic [DW/8-1:0]    s_sel_o,
  output logic               s_we_o,
  output logic               s_cyc_o,
  output logic               s_stb_o,
  output logic [2:0]         s_cti_o,
  output logic [1:0]         s_bte_o,
  input  logic [DW-1:0]      s_dat_i,
  input  logic               s_ack_i,
  input  logic               s_err_i,
  input  logic               s_rty_i,
  output logic [NM-1:0]      grant_o
);

  localparam int LW  = $clog2(NM);
  localparam int SW  = DW / 8;
  localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WDW-1:0] WD_LAST = (TIMEOUT > 0) ? WDW'(TIMEOUT - 1) : '0;

  arb_state_t     state_q;
  logic [NM-1:0]  grant_q;
  logic [LW-1:0]  last_q;
  logic [WDW-1:0] wd_q;
  logic           to_q;     // watchdog error cycle in progress

  logic [NM-1:0]  pick_gnt;
  logic [LW-1:0]  pick_idx;
  logic           any_req;
  logic           owner_cyc;
  logic           slv_resp;

  peripheral_arbiter_rr_wb #(
    .NM (NM),
    .LW (LW)
  ) u_rr (
    .req_i  (m_cyc_i),
    .last_i (last_q),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx),
    .any_o  (any_req)
  );

  assign owner_cyc = |(m_cyc_i & grant_q);
  assign slv_resp  = s_ack_i | s_err_i | s_rty_i;

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      last_q  <= LW'(NM - 1);
      wd_q    <= '0;
      to_q    <= 1'b0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          wd_q <= '0;
          to_q <= 1'b0;
          if (any_req) begin
            grant_q <= pick_gnt;
            last_q  <= pick_idx;
            state_q <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (!owner_cyc) begin
            grant_q <= '0;
            wd_q    <= '0;
            to_q    <= 1'b0;
            state_q <= ARB_IDLE;
          end else if (TIMEOUT == 0) begin
            wd_q <= '0;
            to_q <= 1'b0;
          end else if (to_q) begin
            // err pulse lasts exactly one cycle; the watchdog restarts afterwards
            to_q <= 1'b0;
            wd_q <= '0;
          end else if (s_stb_o && !slv_resp) begin
            if (wd_q == WD_LAST) begin
              to_q <= 1'b1;
              wd_q <= '0;
            end else begin
              wd_q <= wd_q + 1'b1;
            end
          end else begin
            wd_q <= '0;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  // grant_q is zero whenever idle or in reset, so every output falls to 0 then
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_cti_o = '0;
    s_bte_o = '0;
    for (int i = 0; i < NM; i++) begin
      if (grant_q[i]) begin
        s_adr_o = m_adr_i[i*AW +: AW];
        s_dat_o = m_dat_i[i*DW +: DW];
        s_sel_o = m_sel_i[i*SW +: SW];
        s_we_o  = m_we_i[i];
        s_cyc_o = m_cyc_i[i];
        s_stb_o = m_stb_i[i] & ~to_q;
        s_cti_o = m_cti_i[i*3 +: 3];
        s_bte_o = m_bte_i[i*2 +: 2];
      end
    end
  end

  assign m_ack_o = grant_q & {NM{s_ack_i}};
  assign m_err_o = grant_q & {NM{s_err_i | to_q}};
  assign m_rty_o = grant_q & {NM{s_rty_i}};
  assign m_dat_o = (|grant_q) ? s_dat_i : '0;
  assign grant_o = grant_q;

endmodule

// File: tb/tb_peripheral_arbiter_wb.sv
// tb_peripheral_arbiter_wb
// Self-checking bench: directed scenarios plus randomized masters and slave,
// all outputs compared every cycle against a behavioural owner/queue model.
module tb_peripheral_arbiter_wb;
  import peripheral_wb_pkg::*;

  localparam int NM = 4;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NM*AW-1:0] m_adr;
  logic [NM*DW-1:0] m_dat;
  logic [NM*4-1:0]  m_sel;
  logic [NM-1:0]    m_we, m_cyc, m_stb;
  logic [NM*3-1:0]  m_cti;
  logic [NM*2-1:0]  m_bte;
  logic [DW-1:0]    m_dat_o;
  logic [NM-1:0]    m_ack_o, m_err_o, m_rty_o, grant_o;
  logic [AW-1:0]    s_adr_o;
  logic [DW-1:0]    s_dat_o;
  logic [3:0]       s_sel_o;
  logic             s_we_o, s_cyc_o, s_stb_o;
  logic [2:0]       s_cti_o;
  logic [1:0]       s_bte_o;
  logic [DW-1:0]    s_dat;
  logic             s_ack, s_err, s_rty;

  always #5 clk = ~clk;

  peripheral_arbiter_wb #(.NM(NM), .DW(DW), .AW(AW), .TIMEOUT(TO)) dut (
    .wb_clk  (clk),     .wb_rst_n(rst_n),
    .m_adr_i (m_adr),   .m_dat_i (m_dat),   .m_sel_i (m_sel),
    .m_we_i  (m_we),    .m_cyc_i (m_cyc),   .m_stb_i (m_stb),
    .m_cti_i (m_cti),   .m_bte_i (m_bte),
    .m_dat_o (m_dat_o), .m_ack_o (m_ack_o), .m_err_o (m_err_o), .m_rty_o (m_rty_o),
    .s_adr_o (s_adr_o), .s_dat_o (s_dat_o), .s_sel_o (s_sel_o), .s_we_o  (s_we_o),
    .s_cyc_o (s_cyc_o), .s_stb_o (s_stb_o), .s_cti_o (s_cti_o), .s_bte_o (s_bte_o),
    .s_dat_i (s_dat),   .s_ack_i (s_ack),   .s_err_i (s_err),   .s_rty_i (s_rty),
    .grant_o (grant_o)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: who owns the bus, who won last, how many consecutive
  // unanswered strobes the owner has seen, and whether a timeout error is due.
  int owner   = -1;
  int last_m  = NM - 1;
  int stall   = 0;
  bit to_pend = 1'b0;
  int gq[$];
  logic [NM-1:0] prev_gnt = '0;

  task automatic compare_outputs();
    logic [31:0] e_adr, e_dat, e_rdat;
    logic [3:0]  e_sel, e_gnt, e_ack, e_err, e_rty;
    logic [7:0]  e_ctl;
    int o;
    e_adr = '0; e_dat = '0; e_rdat = '0; e_sel = '0;
    e_gnt = '0; e_ack = '0; e_err = '0; e_rty = '0; e_ctl = '0;
    o = owner;
    if (rst_n && o >= 0) begin
      e_gnt  = 4'b0001 << o;
      e_adr  = m_adr[o*AW +: AW];
      e_dat  = m_dat[o*DW +: DW];
      e_sel  = m_sel[o*4 +: 4];
      e_ctl  = {m_we[o], m_cyc[o], m_stb[o] & ~to_pend, m_cti[o*3 +: 3], m_bte[o*2 +: 2]};
      e_ack  = 4'(s_ack) << o;
      e_err  = 4'(s_err | to_pend) << o;
      e_rty  = 4'(s_rty) << o;
      e_rdat = s_dat;
    end
    check("grant", grant_o, e_gnt);
    check("s_adr", s_adr_o, e_adr);
    check("s_dat", s_dat_o, e_dat);
    check("s_sel", s_sel_o, e_sel);
    check("s_ctl", {s_we_o, s_cyc_o, s_stb_o, s_cti_o, s_bte_o}, e_ctl);
    check("m_ack", m_ack_o, e_ack);
    check("m_err", m_err_o, e_err);
    check("m_rty", m_rty_o, e_rty);
    check("m_dat", m_dat_o, e_rdat);
    if (grant_o != '0 && prev_gnt == '0) begin
      for (int i = 0; i < NM; i++) if (grant_o[i]) gq.push_back(i);
    end
    prev_gnt = grant_o;
  endtask

  // What happens at the coming rising edge, given the inputs now applied.
  task automatic model_advance();
    int c;
    if (!rst_n) begin
      owner = -1; last_m = NM - 1; stall = 0; to_pend = 1'b0;
      return;
    end
    if (owner < 0) begin
      for (int k = 1; k <= NM; k++) begin
        c = (last_m + k) % NM;
        if (m_cyc[c]) begin
          owner = c; last_m = c; stall = 0; to_pend = 1'b0;
          break;
        end
      end
    end else if (!m_cyc[owner]) begin
      owner = -1; stall = 0; to_pend = 1'b0;
    end else if (to_pend) begin
      to_pend = 1'b0; stall = 0;
    end else if (m_stb[owner] && !(s_ack || s_err || s_rty)) begin
      stall++;
      if (stall == TO) begin
        to_pend = 1'b1; stall = 0;
      end
    end else begin
      stall = 0;
    end
  endtask

  // One clock: check mid-cycle, advance model, land just after the next edge.
  task automatic step();
    @(negedge clk);
    compare_outputs();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic set_master(input int i, input logic [31:0] adr, input logic [31:0] dat,
                            input logic we, input logic [2:0] cti, input logic cyc, input logic stb);
    m_adr[i*AW +: AW] = adr;
    m_dat[i*DW +: DW] = dat;
    m_sel[i*4 +: 4]   = 4'hF;
    m_we[i]           = we;
    m_cti[i*3 +: 3]   = cti;
    m_bte[i*2 +: 2]   = 2'b00;
    m_cyc[i]          = cyc;
    m_stb[i]          = stb;
  endtask

  task automatic clear_all();
    m_adr = '0; m_dat = '0; m_sel = '0; m_we = '0; m_cyc = '0; m_stb = '0;
    m_cti = '0; m_bte = '0; s_dat = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int hold, ack_cnt, pos, exp_ord[5];
    bit silent;
    int r;
    exp_ord = '{0, 1, 2, 3, 0};
    clear_all();
    rst_n = 1'b0;
    step();
    check("rst_grant", grant_o, 4'b0000);
    check("rst_scyc", {s_cyc_o, s_stb_o}, 2'b00);
    step();
    rst_n = 1'b1;

    // Single master write
    set_master(1, 32'h100, 32'hDEADBEEF, 1'b1, CTI_CLASSIC, 1'b1, 1'b1);
    step();
    check("t1_grant", grant_o, 4'b0010);
    check("t1_adr", s_adr_o, 32'h100);
    check("t1_sel", s_sel_o, 4'hF);
    check("t1_wdat", s_dat_o, 32'hDEADBEEF);
    s_ack = 1'b1;
    #1;
    check("t1_ack", m_ack_o, 4'b0010);
    step();
    set_master(1, 32'h0, 32'h0, 1'b0, CTI_CLASSIC, 1'b0, 1'b0);
    s_ack = 1'b0;
    step();
    step();

    // All four from reset: strict rotation, one idle cycle between grants
    do_reset();
    gq.delete();
    hold = 0;
    s_ack = 1'b1;
    for (int i = 0; i < NM; i++) set_master(i, 32'h1000 * i, 32'h0, 1'b0, CTI_CLASSIC, 1'b1, 1'b1);
    for (int cyc = 0; cyc < 60 && gq.size() < 6; cyc++) begin
      if (grant_o != '0) hold++; else hold = 0;
      m_cyc = (hold >= 2) ? ~grant_o : 4'hF;
      m_stb = m_cyc;
      step();
    end
    check("rr_count", 64'(gq.size() >= 5), 64'd1);
    for (int k = 0; k < 5 && k < gq.size(); k++) check($sformatf("rr_order%0d", k), gq[k], exp_ord[k]);
    clear_all();
    step();
    step();

    // m2 incrementing burst; m0 waits until m2 drops cyc
    set_master(2, 32'h200, 32'h0, 1'b0, CTI_INC, 1'b1, 1'b1);
    step();
    check("bu_grant2", grant_o, 4'b0100);
    set_master(0, 32'h300, 32'h0, 1'b0, CTI_CLASSIC, 1'b1, 1'b1);
    s_ack = 1'b1;
    ack_cnt = 0;
    for (int b = 0; b < 4; b++) begin
      set_master(2, 32'h200 + 32'(4 * b), 32'h0, 1'b0, (b == 3) ? CTI_END : CTI_INC, 1'b1, 1'b1);
      #1;
      if (m_ack_o[2]) ack_cnt++;
      check("bu_hold", grant_o, 4'b0100);
      step();
    end
    check("bu_acks", ack_cnt, 4);
    set_master(2, 32'h0, 32'h0, 1'b0, CTI_CLASSIC, 1'b0, 1'b0);
    s_ack = 1'b0;
    step();
    check("bu_idle", grant_o, 4'b0000);
    step();
    check("bu_grant0", grant_o, 4'b0001);
    clear_all();
    step();
    step();

    // Dead slave: watchdog error on the 9th cycle of the stalled strobe
    set_master(3, 32'h400, 32'h0, 1'b0, CTI_CLASSIC, 1'b1, 1'b1);
    for (int w = 0; w < 4 && grant_o != 4'b1000; w++) step();
    pos = 0;
    for (int c = 1; c <= 20; c++) begin
      if (m_err_o[3]) begin
        pos = c;
        check("wd_stb", s_stb_o, 1'b0);
        check("wd_gnt", grant_o, 4'b1000);
        break;
      end
      step();
    end
    check("wd_pos", pos, 9);
    step();
    m_stb[3] = 1'b0;
    #1;
    check("wd_once", m_err_o, 4'b0000);
    check("wd_keep", grant_o, 4'b1000);
    step();
    clear_all();
    step();
    step();

    // Slave error response routed only to the owner
    set_master(1, 32'h500, 32'h0, 1'b0, CTI_CLASSIC, 1'b1, 1'b1);
    for (int w = 0; w < 4 && grant_o != 4'b0010; w++) step();
    s_err = 1'b1;
    #1;
    check("er_route", m_err_o, 4'b0010);
    check("er_noack", m_ack_o, 4'b0000);
    step();
    clear_all();
    step();
    step();

    // Reset in the middle of a burst
    set_master(2, 32'h600, 32'h0, 1'b1, CTI_INC, 1'b1, 1'b1);
    for (int w = 0; w < 4 && grant_o != 4'b0100; w++) step();
    s_ack = 1'b1;
    step();
    rst_n = 1'b0;
    #1;
    check("rm_grant", grant_o, 4'b0000);
    check("rm_slave", {s_cyc_o, s_stb_o, s_adr_o}, 34'd0);
    check("rm_ack", m_ack_o, 4'b0000);
    for (int i = 0; i < NM; i++) set_master(i, 32'h700 + 32'(i), 32'h0, 1'b0, CTI_CLASSIC, 1'b1, 1'b1);
    s_ack = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    check("rm_first", grant_o, 4'b0001);
    clear_all();
    step();
    step();

    // Randomized traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < NM; i++) begin
        if (!m_cyc[i]) begin
          if ($urandom_range(0, 99) < 20) m_cyc[i] = 1'b1;
        end else if ($urandom_range(0, 99) < 12) begin
          m_cyc[i] = 1'b0;
        end
        m_stb[i]          = m_cyc[i] && ($urandom_range(0, 99) < 75);
        m_adr[i*AW +: AW] = $urandom;
        m_dat[i*DW +: DW] = $urandom;
        m_sel[i*4 +: 4]   = 4'($urandom_range(0, 15));
        m_we[i]           = 1'($urandom_range(0, 1));
        m_cti[i*3 +: 3]   = 3'($urandom_range(0, 7));
        m_bte[i*2 +: 2]   = 2'($urandom_range(0, 3));
      end
      silent = ((cyc / 50) % 5) == 4;
      r = $urandom_range(0, 99);
      s_ack = !silent && r < 40;
      s_err = !silent && r >= 40 && r < 45;
      s_rty = !silent && r >= 45 && r < 50;
      s_dat = $urandom;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
